cmac_link_supervisor: RTL

- Sequences CMAC link bring-up and recovery from the init_clk domain.
- Pulses the GT/core reset, waits for RX alignment with a timeout, and debounces remote-fault clearance before enabling TX.
- Re-enters alignment on link loss and counts retries and link flaps.
- Sits between the board init logic (enable) and the CMAC ctl_*/stat_* ports.

---
 rtl/cmac_sup_pkg.sv | 19 +
 rtl/cmac_sup_timer.sv | 27 ++
 rtl/cmac_link_supervisor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cmac_sup_pkg.sv
// Shared state encoding and helpers for the CMAC link supervisor.
package cmac_sup_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE          = 3'd0,
      ST_GT_RESET      = 3'd1,
      ST_WAIT_ALIGN    = 3'd2,
      ST_WAIT_RF_CLEAR = 3'd3,
      ST_UP            = 3'd4,
      ST_FAILED        = 3'd5
   } state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/cmac_sup_timer.sv
// Loadable down-counter shared by the reset-pulse, align-timeout and debounce phases.
// Loading N-1 makes o_expire assert on the N-th cycle after the load.
module cmac_sup_timer #(
   parameter int W = 4
) (
   input  logic         init_clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expire
);

   logic [W-1:0] r_value;

   always_ff @(posedge init_clk or posedge reset) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (r_value != '0) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_expire = (r_value == '0);

endmodule

// File: rtl/cmac_link_supervisor.sv
// CMAC link bring-up / recovery sequencer in the init_clk domain.
// Optional retry limit enabled by defining CMAC_SUP_RETRY_LIMIT_EN.
//
// state            | meaning
// IDLE             | link held down, waiting for enable
// GT_RESET         | gt_reset pulse in progress
// WAIT_ALIGN       | RX enabled, sending RFI, waiting for alignment or timeout
// WAIT_RF_CLEAR    | aligned, debouncing remote-fault clearance
// UP               | TX enabled, link_up asserted
// FAILED           | retry limit reached, everything off until enable drops
module cmac_link_supervisor
   import cmac_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int ALIGN_TIMEOUT    = 1_000_000,
   parameter int FAULT_DEBOUNCE   = 64,
   parameter int CNT_W            = 8,
   parameter int MAX_RETRIES      = 8
) (
   input  logic               init_clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               stat_rx_aligned,
   input  logic               stat_rx_remote_fault,
   output logic               gt_reset,
   output logic               ctl_rx_enable,
   output logic               ctl_tx_enable,
   output logic               ctl_tx_send_rfi,
   output logic               ctl_tx_send_idle,
   output logic               link_up,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   retry_count,
   output logic [CNT_W-1:0]   flap_count
);

   localparam int TMR_MAX_A = (RST_PULSE_CYCLES > ALIGN_TIMEOUT) ? RST_PULSE_CYCLES : ALIGN_TIMEOUT;
   localparam int TMR_MAX   = (TMR_MAX_A > FAULT_DEBOUNCE) ? TMR_MAX_A : FAULT_DEBOUNCE;
   localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] LD_RST   = TMR_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] LD_ALIGN = TMR_W'(ALIGN_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LD_DEB   = TMR_W'(FAULT_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef CMAC_SUP_RETRY_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_e             r_state;
   state_e             w_nxt;
   logic               r_gt_reset, r_rx_en, r_tx_en, r_send_rfi, r_send_idle, r_link_up;
   logic [CNT_W-1:0]   r_retry, r_flap;
   logic               w_tmr_load, w_tmr_exp, w_timeout, w_retry_limit;
   logic [TMR_W-1:0]   w_tmr_val;

   cmac_sup_timer #(.W(TMR_W)) u_timer (
      .init_clk   (init_clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_expire   (w_tmr_exp)
   );

   assign w_retry_limit = LIMIT_EN && (32'(r_retry) == 32'(MAX_RETRIES - 1));
   assign w_timeout     = (r_state == ST_WAIT_ALIGN) && !stat_rx_aligned && w_tmr_exp;

   // Next state and timer reload share one decision so the timer is primed on the entry edge.
   always_comb begin
      w_nxt      = r_state;
      w_tmr_load = 1'b0;
      w_tmr_val  = LD_RST;
      if (!enable) begin
         w_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nxt      = ST_GT_RESET;
               w_tmr_load = 1'b1;
               w_tmr_val  = LD_RST;
            end
            ST_GT_RESET: if (w_tmr_exp) begin
               w_nxt      = ST_WAIT_ALIGN;
               w_tmr_load = 1'b1;
               w_tmr_val  = LD_ALIGN;
            end
            ST_WAIT_ALIGN: begin
               if (stat_rx_aligned) begin
                  w_nxt      = ST_WAIT_RF_CLEAR;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = LD_DEB;
               end else if (w_tmr_exp) begin
                  w_nxt      = w_retry_limit ? ST_FAILED : ST_GT_RESET;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = LD_RST;
               end
            end
            ST_WAIT_RF_CLEAR: begin
               if (!stat_rx_aligned) begin
                  w_nxt      = ST_WAIT_ALIGN;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = LD_ALIGN;
               end else if (stat_rx_remote_fault) begin
                  w_tmr_load = 1'b1;
                  w_tmr_val  = LD_DEB;
               end else if (w_tmr_exp) begin
                  w_nxt = ST_UP;
               end
            end
            ST_UP: if (!stat_rx_aligned) begin
               w_nxt      = ST_WAIT_ALIGN;
               w_tmr_load = 1'b1;
               w_tmr_val  = LD_ALIGN;
            end
            ST_FAILED: w_nxt = ST_FAILED;
            default:   w_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge init_clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_gt_reset  <= 1'b0;
         r_rx_en     <= 1'b0;
         r_tx_en     <= 1'b0;
         r_send_rfi  <= 1'b0;
         r_send_idle <= 1'b0;
         r_link_up   <= 1'b0;
         r_retry     <= '0;
         r_flap      <= '0;
      end else begin
         r_state     <= w_nxt;
         r_gt_reset  <= (w_nxt == ST_GT_RESET);
         r_rx_en     <= (w_nxt inside {ST_WAIT_ALIGN, ST_WAIT_RF_CLEAR, ST_UP});
         r_tx_en     <= (w_nxt == ST_UP);
         r_send_rfi  <= (w_nxt == ST_WAIT_ALIGN);
         r_send_idle <= stat_rx_remote_fault && (w_nxt inside {ST_WAIT_ALIGN, ST_WAIT_RF_CLEAR, ST_UP});
         r_link_up   <= (w_nxt == ST_UP);
         if (w_nxt == ST_IDLE || (w_nxt == ST_UP && r_state != ST_UP)) begin
            r_retry <= '0;
         end else if (w_timeout) begin
            r_retry <= CNT_W'(sat_inc(32'(r_retry), 32'(CNT_MAX)));
         end
         if (r_state == ST_UP && w_nxt == ST_WAIT_ALIGN) begin
            r_flap <= CNT_W'(sat_inc(32'(r_flap), 32'(CNT_MAX)));
         end
      end
   end

   assign gt_reset         = r_gt_reset;
   assign ctl_rx_enable    = r_rx_en;
   assign ctl_tx_enable    = r_tx_en;
   assign ctl_tx_send_rfi  = r_send_rfi;
   assign ctl_tx_send_idle = r_send_idle;
   assign link_up          = r_link_up;
   assign state            = r_state;
   assign retry_count      = r_retry;
   assign flap_count       = r_flap;

endmodule
